fft_frame_streamer: RTL
=======================

# fft_frame_streamer

Frame-level front/back end for the 32-point DIT FFT core. It accepts real samples over a valid/ready stream and assembles them into a frame. It holds the frame stable on a flattened bus into the FFT core and waits the core's fixed latency. It then captures the complex results and streams them out over a second valid/ready interface, in natural or bit-reversed order. It replaces address-mapped write/read register files with handshaked, back-pressure-aware frame sequencing.

## Interface
- DATA_WIDTH, 16, width of one real sample and of each of re/im in a result
- NPTS, 32, points per frame; power of two, 4..256
- ADDR_WIDTH, 5, log2(NPTS)
- CORE_LATENCY, 8, cycles from a stable core_in to a valid core_out; ≥1
- OUT_BITREV, 0, 1 = results read out in bit-reversed index order
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous abort: drop the partial frame or readout, return to LOAD
- in_data  in  DATA_WIDTH  real sample, two's complement
- in_valid  in  1  sample offered
- in_ready  out  1  block accepts the sample this cycle
- core_in  out  NPTS*DATA_WIDTH  frame to the FFT core; slot k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- core_out  in  NPTS*2*DATA_WIDTH  core results; slot k = {im, re} at bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH]
- out_data  out  2*DATA_WIDTH  result word {im, re}
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the word
- out_last  out  1  marks the final word of a frame, qualified by out_valid
- busy  out  1  state is COMPUTE or OUT
- frame_done  out  1  one-cycle pulse after the last output handshake
- frame_cnt  out  16  completed frames, wraps at 16'hFFFF→0

## Operation
- States:
  - LOAD: sample index wr_idx counts 0..NPTS-1.
  - COMPUTE: latency counter counts down.
  - OUT: read index rd_idx counts 0..NPTS-1.
- LOAD: in_ready=1.
  - On in_valid&in_ready, in_buf[wr_idx]←in_data and wr_idx increments.
  - The handshake at wr_idx=NPTS-1 moves the block to COMPUTE and sets wr_idx←0.
- COMPUTE: in_ready=0; core_in is held unchanged.
  - The counter loads CORE_LATENCY-1 on entry and decrements each cycle.
  - At count 0, out_buf[k]←core_out slot k for all k, and the block moves to OUT.
- OUT: out_valid=1.
  - out_data=out_buf[j], where j=rd_idx, or bit-reverse(rd_idx) over ADDR_WIDTH bits when OUT_BITREV=1.
  - out_last=1 when rd_idx=NPTS-1.
  - On out_valid&out_ready, rd_idx increments. If out_valid is held with out_ready=0, out_data and out_last stay stable.
- Last output handshake: move to LOAD, set rd_idx←0, pulse frame_done, increment frame_cnt.
- core_in always reflects in_buf. It changes only in LOAD, so it is stable throughout COMPUTE and OUT.
- clear (any state, priority over every handshake):
  - Next state is LOAD; wr_idx, rd_idx and the latency counter go to 0.
  - out_valid drops next cycle; no frame_done; frame_cnt is unchanged.
  - in_buf and out_buf contents are retained.
  - A sample presented in the clear cycle is not accepted: in_ready=0 that cycle.
- No arithmetic in this block; results pass through bit-exact. No saturation or scaling.

## Timing
- Reset values: state LOAD; wr_idx, rd_idx, counter, frame_cnt = 0; in_buf, out_buf = 0.
  - Outputs: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, frame_done=0, core_in=0.
- in_ready is registered. It is 0 during rst and rises at the first rising edge after rst deasserts.
- Outputs out_valid, out_data, out_last, busy and frame_done are registered. out_data is updated in the same cycle as the rd_idx advance.
- Latencies:
  - Last input handshake at edge T: busy=1 and in_ready=0 from T.
  - Capture happens at edge T+CORE_LATENCY; out_valid=1 from edge T+CORE_LATENCY+1.
  - With out_ready held high, NPTS output beats follow back-to-back. frame_done is high during the cycle after the last beat, and in_ready=1 in that same cycle.
- Minimum frame period: NPTS + CORE_LATENCY + 1 + NPTS cycles.
- Async rst mid-frame: immediate return to the reset values above; the partial frame is lost.

## Test plan
Bench core model: slot k core_out = {16'h0000, core_in slot k}, registered through a CORE_LATENCY-deep pipeline.
- Ramp frame: samples 0..31 with in_valid, then out_ready=1 → 32 words 0x0000_0000..0x0000_001F with out_last on word 31. First out_valid arrives 9 cycles after the last input edge; frame_done pulses once; frame_cnt=1.
- OUT_BITREV=1 with the same ramp → word sequence 0,16,8,24,4,... and word 1 = 0x0000_0010.
- Backpressure: toggle out_ready 1/0 every cycle → out_data is stable while stalled and exactly 32 beats occur. Pull in_valid low randomly during LOAD → exactly 32 samples are captured.
- clear asserted after 10 input samples → in_ready stays 1; the next 32 samples form the frame with sample 0 in slot 0; no frame_done from the aborted frame.
- clear asserted mid-OUT at rd_idx=5 → out_valid=0 next cycle; frame_cnt is unchanged; the following frame completes normally.
- rst pulse during COMPUTE → busy=0 and out_valid=0 immediately; in_ready=1 one edge after release; frame_cnt=0.

Source files
------------

// File: rtl/fft_frame_streamer_if.sv
// Sample-in and {im,re}-out valid/ready streams of fft_frame_streamer.
// The block itself connects through the slave modport.
interface fft_frame_streamer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [2*DATA_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/fft_frame_streamer.sv
// Frame sequencer around the FFT core: collect NPTS samples, hold them for the
// core's fixed latency, capture the results and stream them out.
module fft_frame_streamer #(
    parameter int DATA_WIDTH   = 16,
    parameter int NPTS         = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int CORE_LATENCY = 8,
    parameter int OUT_BITREV   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    fft_frame_streamer_if.slave            strm,
    output logic [NPTS*DATA_WIDTH-1:0]     core_in,
    input  logic [NPTS*2*DATA_WIDTH-1:0]   core_out,
    output logic                           busy,
    output logic                           frame_done,
    output logic [15:0]                    frame_cnt
);
    localparam int CNT_W = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NPTS - 1);
    localparam logic [CNT_W-1:0]      LAT_INIT = CNT_W'(CORE_LATENCY - 1);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_idx_q, wr_idx_d;
    logic [ADDR_WIDTH-1:0]   rd_idx_q, rd_idx_d;
    logic [ADDR_WIDTH-1:0]   rd_nxt;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0]   in_buf_q [NPTS];
    logic [DATA_WIDTH-1:0]   in_buf_d [NPTS];
    logic [2*DATA_WIDTH-1:0] out_buf_q [NPTS];
    logic [2*DATA_WIDTH-1:0] out_buf_d [NPTS];
    logic                    in_fire, out_fire;

    function automatic logic [ADDR_WIDTH-1:0] rd_map(input logic [ADDR_WIDTH-1:0] idx);
        logic [ADDR_WIDTH-1:0] r;
        r = idx;
        if (OUT_BITREV != 0) begin
            for (int b = 0; b < ADDR_WIDTH; b++) r[b] = idx[ADDR_WIDTH-1-b];
        end
        return r;
    endfunction

    // clear wins over any handshake, so it also masks the advertised ready
    assign strm.in_ready  = in_ready_q & ~clear;
    assign in_fire        = strm.in_valid & in_ready_q & ~clear;
    assign out_fire       = out_valid_q & strm.out_ready & ~clear;
    assign rd_nxt         = rd_idx_q + ADDR_WIDTH'(1);

    assign strm.out_data  = out_data_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_last  = out_last_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign frame_cnt      = frame_cnt_q;

    for (genvar k = 0; k < NPTS; k++) begin : g_core_in
        assign core_in[k*DATA_WIDTH +: DATA_WIDTH] = in_buf_q[k];
    end

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        cnt_d        = cnt_q;
        frame_cnt_d  = frame_cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        in_buf_d     = in_buf_q;
        out_buf_d    = out_buf_q;

        if (clear) begin
            state_d     = S_LOAD;
            wr_idx_d    = '0;
            rd_idx_d    = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_fire) begin
                        in_buf_d[wr_idx_q] = strm.in_data;
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_d = '0;
                            cnt_d    = LAT_INIT;
                            state_d  = S_COMPUTE;
                        end else begin
                            wr_idx_d = wr_idx_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (cnt_q == '0) begin
                        for (int k = 0; k < NPTS; k++)
                            out_buf_d[k] = core_out[k*2*DATA_WIDTH +: 2*DATA_WIDTH];
                        state_d = S_OUT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_OUT: begin
                    // First OUT cycle primes the output register from the captured frame
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = out_buf_q[rd_map(rd_idx_q)];
                        out_last_d  = (rd_idx_q == LAST_IDX);
                    end else if (out_fire) begin
                        if (rd_idx_q == LAST_IDX) begin
                            state_d      = S_LOAD;
                            rd_idx_d     = '0;
                            out_valid_d  = 1'b0;
                            out_last_d   = 1'b0;
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 16'd1;
                        end else begin
                            rd_idx_d   = rd_nxt;
                            out_data_d = out_buf_q[rd_map(rd_nxt)];
                            out_last_d = (rd_nxt == LAST_IDX);
                        end
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end

        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOAD;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            cnt_q        <= '0;
            frame_cnt_q  <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NPTS; k++) begin
                in_buf_q[k]  <= '0;
                out_buf_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            cnt_q        <= cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            in_buf_q     <= in_buf_d;
            out_buf_q    <= out_buf_d;
        end
    end
endmodule
